// File: rtl/grid_mem_arbiter.sv
// Single-port grid RAM arbiter: display reads first, game access in idle or stolen slots, plus a 256-cell clear sequencer.
// Read latency 2 cycles from grant to valid; game_gnt is combinational and the game holds its request until granted.
module grid_mem_arbiter #(
    parameter int MAX_WAIT = 64,
    parameter int CELL_W   = 7
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [3:0]        disp_x,
    input  logic [3:0]        disp_y,
    output logic [CELL_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              game_req,
    input  logic              game_we,
    input  logic [3:0]        game_x,
    input  logic [3:0]        game_y,
    input  logic [CELL_W-1:0] game_wdata,
    output logic              game_gnt,
    output logic [CELL_W-1:0] game_rdata,
    output logic              game_rvalid,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic [7:0]        mem_addr,
    output logic              mem_we,
    output logic [CELL_W-1:0] mem_wdata,
    input  logic [CELL_W-1:0] mem_rdata
);

    localparam logic [7:0] STARVE_MAX = 8'(MAX_WAIT);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] clr_addr;
    logic [7:0] starve_cnt;
    logic [7:0] addr_q;
    logic       game_win;
    logic       disp_win;
    logic       tag_disp;
    logic       tag_game;
    logic       disp_capture;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The clear_start cycle grants nobody, so no read can complete inside CLEAR.
    always_comb begin
        state_nxt = state;
        game_win  = 1'b0;
        disp_win  = 1'b0;
        mem_addr  = addr_q;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_nxt = CLEAR;
                end else if (game_req && (!disp_req || starve_cnt == STARVE_MAX)) begin
                    game_win  = 1'b1;
                    mem_addr  = {game_y, game_x};
                    mem_we    = game_we;
                    mem_wdata = game_wdata;
                end else if (disp_req) begin
                    disp_win = 1'b1;
                    mem_addr = {disp_y, disp_x};
                end
            end
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = clr_addr;
                if (clr_addr == 8'hFF) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign game_gnt   = game_win;
    assign clear_busy = (state == CLEAR);

    // A display read landing as CLEAR begins is dropped so disp_valid stays low all through CLEAR.
    assign disp_capture = tag_disp && (state_nxt == IDLE);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            clr_addr    <= '0;
            starve_cnt  <= '0;
            addr_q      <= '0;
            tag_disp    <= 1'b0;
            tag_game    <= 1'b0;
            disp_data   <= '0;
            disp_valid  <= 1'b0;
            game_rdata  <= '0;
            game_rvalid <= 1'b0;
        end else begin
            addr_q   <= mem_addr;
            tag_disp <= disp_win;
            tag_game <= game_win && !game_we;
            if (state == CLEAR) begin
                clr_addr <= clr_addr + 8'd1;
            end
            if (state == IDLE) begin
                if (!game_req || game_win) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != STARVE_MAX) begin
                    starve_cnt <= starve_cnt + 8'd1;
                end
            end
            disp_valid <= disp_capture;
            if (disp_capture) begin
                disp_data <= mem_rdata;
            end
            game_rvalid <= tag_game;
            if (tag_game) begin
                game_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Bench for grid_mem_arbiter: vector table for single-cycle arbitration, hand sequences for starvation, clear and reset.
module tb_grid_mem_arbiter;

    localparam int CW = 7;
    localparam int MW = 4;

    logic          clock = 1'b0;
    logic          rst = 1'b1;
    logic          disp_req = 1'b0;
    logic [3:0]    disp_x = '0;
    logic [3:0]    disp_y = '0;
    logic [CW-1:0] disp_data;
    logic          disp_valid;
    logic          game_req = 1'b0;
    logic          game_we = 1'b0;
    logic [3:0]    game_x = '0;
    logic [3:0]    game_y = '0;
    logic [CW-1:0] game_wdata = '0;
    logic          game_gnt;
    logic [CW-1:0] game_rdata;
    logic          game_rvalid;
    logic          clear_start = 1'b0;
    logic          clear_busy;
    logic [7:0]    mem_addr;
    logic          mem_we;
    logic [CW-1:0] mem_wdata;
    logic [CW-1:0] mem_rdata = '0;

    always #5 clock = ~clock;

    grid_mem_arbiter #(.MAX_WAIT(MW), .CELL_W(CW)) dut (
        .clock(clock), .rst(rst),
        .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .game_req(game_req), .game_we(game_we), .game_x(game_x), .game_y(game_y),
        .game_wdata(game_wdata), .game_gnt(game_gnt),
        .game_rdata(game_rdata), .game_rvalid(game_rvalid),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous RAM, read-before-write.
    logic [CW-1:0] ram [0:255];
    always @(posedge clock) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
    end

    logic [CW-1:0] ref_mem [0:255];

    function automatic logic [CW-1:0] init_val(input int i);
        logic [CW-1:0] v;
        v = 7'((i * 5 + 3) % 128);
        if (i == 0) v = 7'h01;
        if (i == 1) v = 7'h0B;
        if (i == 2) v = 7'h7F;
        if (i == 8'h53) v = 7'h35;
        return v;
    endfunction

    typedef struct {
        logic [CW-1:0] data;
        int            due;
    } exp_t;

    exp_t          dq[$];
    exp_t          gq[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    logic [CW-1:0] last_disp = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_disp(input logic [7:0] a);
        exp_t e;
        e.data = ref_mem[a];
        e.due  = cyc + 2;
        dq.push_back(e);
    endtask

    task automatic push_game(input logic [7:0] a);
        exp_t e;
        e.data = ref_mem[a];
        e.due  = cyc + 2;
        gq.push_back(e);
    endtask

    // Output-side scoreboard: every cycle either an expected pulse is due or the port must be quiet.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (rst) begin
            if (dq.size() > 0 && dq[0].due == cyc) begin
                e = dq.pop_front();
                chk("disp_valid_pulse", 32'(disp_valid), 32'd1);
                chk("disp_data", 32'(disp_data), 32'(e.data));
                last_disp = e.data;
            end else begin
                chk("disp_quiet", 32'({disp_valid, disp_data}), 32'({1'b0, last_disp}));
            end
            if (gq.size() > 0 && gq[0].due == cyc) begin
                e = gq.pop_front();
                chk("game_rvalid_pulse", 32'(game_rvalid), 32'd1);
                chk("game_rdata", 32'(game_rdata), 32'(e.data));
            end else if (game_rvalid) begin
                chk("game_rvalid_unexpected", 32'(game_rvalid), 32'd0);
            end
        end
    end

    typedef struct {
        logic          dreq;
        logic [3:0]    dx, dy;
        logic          greq, gwe;
        logic [3:0]    gx, gy;
        logic [CW-1:0] wd;
        logic          egnt;
        logic [7:0]    eaddr;
        logic          ewe;
    } vec_t;

    vec_t vt[12];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        disp_req = 1'b0; game_req = 1'b0; game_we = 1'b0; clear_start = 1'b0;
    endtask

    task automatic clear_cycle(input int i);
        @(negedge clock);
        chk($sformatf("clear_cyc%0d", i),
            32'({clear_busy, mem_we, game_gnt, mem_addr, mem_wdata}),
            32'({1'b1, 1'b1, 1'b0, 8'(i), 7'h00}));
        @(posedge clock);
        ref_mem[i] = '0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        //           dreq  dx    dy    greq  gwe   gx    gy    wd     egnt  eaddr  ewe
        vt[0]  = '{1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 7'h00, 1'b0, 8'h00, 1'b0};
        vt[1]  = '{1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 7'h00, 1'b0, 8'h01, 1'b0};
        vt[2]  = '{1'b1, 4'd2, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 7'h00, 1'b0, 8'h02, 1'b0};
        vt[3]  = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd3, 4'd5, 7'h00, 1'b1, 8'h53, 1'b0};
        vt[4]  = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd4, 4'd4, 7'h44, 1'b1, 8'h44, 1'b1};
        vt[5]  = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd4, 4'd4, 7'h00, 1'b1, 8'h44, 1'b0};
        vt[6]  = '{1'b1, 4'd4, 4'd4, 1'b0, 1'b0, 4'd0, 4'd0, 7'h00, 1'b0, 8'h44, 1'b0};
        vt[7]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd9, 4'd9, 7'h00, 1'b0, 8'h44, 1'b0};
        vt[8]  = '{1'b1, 4'd7, 4'd9, 1'b1, 1'b0, 4'd1, 4'd1, 7'h00, 1'b0, 8'h97, 1'b0};
        vt[9]  = '{1'b1, 4'd8, 4'd9, 1'b0, 1'b0, 4'd0, 4'd0, 7'h00, 1'b0, 8'h98, 1'b0};
        vt[10] = '{1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 4'd2, 4'd0, 7'h00, 1'b0, 8'h00, 1'b0};
        vt[11] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd2, 4'd0, 7'h00, 1'b1, 8'h02, 1'b0};

        // Reset state
        #1 rst = 1'b0;
        #1;
        chk("reset_ctrl", 32'({clear_busy, disp_valid, game_rvalid, game_gnt, mem_we}), 32'd0);
        chk("reset_data", 32'({disp_data, game_rdata, mem_addr, mem_wdata}), 32'd0);
        repeat (3) @(posedge clock);
        #1 rst = 1'b1;

        // Single-cycle arbitration vectors
        for (int i = 0; i < 12; i++) begin
            disp_req = vt[i].dreq; disp_x = vt[i].dx; disp_y = vt[i].dy;
            game_req = vt[i].greq; game_we = vt[i].gwe; game_x = vt[i].gx; game_y = vt[i].gy;
            game_wdata = vt[i].wd;
            if (vt[i].egnt) begin
                if (vt[i].gwe) ref_mem[vt[i].eaddr] = vt[i].wd;
                else push_game(vt[i].eaddr);
            end else if (vt[i].dreq) begin
                push_disp(vt[i].eaddr);
            end
            @(negedge clock);
            chk($sformatf("vec%0d_gnt", i), 32'(game_gnt), 32'(vt[i].egnt));
            chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vt[i].eaddr));
            chk($sformatf("vec%0d_we", i), 32'(mem_we), 32'(vt[i].ewe));
            if (vt[i].ewe) chk($sformatf("vec%0d_wdata", i), 32'(mem_wdata), 32'(vt[i].wd));
            tick();
        end
        set_idle();
        repeat (3) tick();

        // Starvation: display streams, game write then game read each steal one slot
        for (int pass = 0; pass < 2; pass++) begin
            game_req = 1'b1; game_we = (pass == 0); game_x = 4'd2; game_y = 4'd2; game_wdata = 7'h21;
            disp_req = 1'b1; disp_y = 4'd1;
            for (int k = 0; k <= MW; k++) begin
                disp_x = 4'(k);
                if (k < MW) push_disp({4'd1, 4'(k)});
                else if (pass == 0) ref_mem[8'h22] = 7'h21;
                else push_game(8'h22);
                @(negedge clock);
                if (k < MW) begin
                    chk($sformatf("starve%0d_deny%0d", pass, k),
                        32'({game_gnt, mem_we, mem_addr}), 32'({1'b0, 1'b0, 4'd1, 4'(k)}));
                end else begin
                    chk($sformatf("starve%0d_steal", pass),
                        32'({game_gnt, mem_we, mem_addr}), 32'({1'b1, pass == 0, 8'h22}));
                    if (pass == 0) chk("starve_wdata", 32'(mem_wdata), 32'h21);
                end
                tick();
            end
            game_req = 1'b0;
        end
        set_idle();
        repeat (3) tick();

        // Clear with a saturated starvation count: game must win the first IDLE cycle
        game_req = 1'b1; game_we = 1'b0; game_x = 4'd5; game_y = 4'd3;
        disp_req = 1'b1; disp_x = 4'd6; disp_y = 4'd6;
        for (int k = 0; k < MW; k++) begin
            if (k < MW - 1) push_disp(8'h66);
            @(negedge clock);
            chk($sformatf("pre_clear_deny%0d", k), 32'(game_gnt), 32'd0);
            tick();
        end
        clear_start = 1'b1;
        @(negedge clock);
        chk("clear_start_cycle", 32'({game_gnt, clear_busy}), 32'd0);
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 256; i++) clear_cycle(i);
        push_game(8'h35);
        @(negedge clock);
        chk("post_clear_grant", 32'({clear_busy, game_gnt, mem_addr}), 32'({1'b0, 1'b1, 8'h35}));
        tick();
        game_req = 1'b0; disp_x = 4'd0; disp_y = 4'd0;
        push_disp(8'h00);
        tick();
        set_idle();
        repeat (3) tick();

        // Reset in mid-clear, then a full restart from address 0
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 100; i++) clear_cycle(i);
        @(negedge clock);
        chk("clear_at_100", 32'(mem_addr), 32'd100);
        #1 rst = 1'b0;
        dq.delete(); gq.delete(); last_disp = '0;
        #1;
        chk("midclear_reset_ctrl", 32'({clear_busy, disp_valid, game_rvalid, game_gnt, mem_we}), 32'd0);
        chk("midclear_reset_data", 32'({disp_data, game_rdata, mem_addr, mem_wdata}), 32'd0);
        repeat (2) @(posedge clock);
        #1 rst = 1'b1;
        @(negedge clock);
        chk("after_reset_idle", 32'(clear_busy), 32'd0);
        tick();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 256; i++) clear_cycle(i);

        // Reset with a game read in flight: no rvalid may follow
        game_req = 1'b1; game_we = 1'b0; game_x = 4'd3; game_y = 4'd5;
        @(negedge clock);
        chk("inflight_grant", 32'(game_gnt), 32'd1);
        tick();
        set_idle();
        @(negedge clock);
        #1 rst = 1'b0;
        dq.delete(); gq.delete(); last_disp = '0;
        #2 rst = 1'b1;
        repeat (4) tick();

        // Read back a cleared cell through the display path
        disp_req = 1'b1; disp_x = 4'd3; disp_y = 4'd5;
        push_disp(8'h53);
        tick();
        set_idle();
        repeat (4) tick();

        chk("scoreboard_drained", 32'(dq.size() + gq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/grid_mem_arbiter.md
Name: grid_mem_arbiter

Overview:
Owns the single-port grid-cell RAM and arbitrates it between the VGA display path and the game-logic engine. Display pixel reads have priority. Game reads and writes are served in display-idle cycles, or by a bounded anti-starvation steal. A built-in clear sequencer zeroes all 256 cells at the start of a new game.

Parameters:
MAX_WAIT, 64, consecutive denied game-request cycles before one display slot is stolen for the game (1..255)
CELL_W, 7, width of a grid cell word: {bombsNear[3:0], flagged, bomb, uncovered}

Ports:
clock  in  1  system clock
rst  in  1  reset; asynchronous, active-low
disp_req  in  1  display needs a cell read this cycle (active grid region)
disp_x  in  4  display grid column
disp_y  in  4  display grid row
disp_data  out  CELL_W  registered cell word for the display; holds its last value
disp_valid  out  1  one-cycle pulse: disp_data updated with this pixel's read
game_req  in  1  game-logic access request; held until granted
game_we  in  1  1=write, 0=read; qualified by game_req
game_x  in  4  game cell column
game_y  in  4  game cell row
game_wdata  in  CELL_W  write data
game_gnt  out  1  combinational; request accepted this cycle
game_rdata  out  CELL_W  registered read data
game_rvalid  out  1  one-cycle pulse: game_rdata valid
clear_start  in  1  pulse: zero the whole grid
clear_busy  out  1  high while the clear sequence runs
mem_addr  out  8  RAM address {y,x}
mem_we  out  1  RAM write enable
mem_wdata  out  CELL_W  RAM write data
mem_rdata  in  CELL_W  RAM read data, valid one cycle after the address (synchronous RAM)

Behaviour:
- Reset (rst=0, async): state IDLE; starve_cnt=0; clr_addr=0. All outputs 0 (disp_data and game_rdata 0), pipeline owner tags cleared.
- State machine has two states: IDLE and CLEAR.
- IDLE, clear_start=1: next state CLEAR. No grant is given in that cycle, even if game_req=1.
- CLEAR:
  - Per cycle: mem_we=1, mem_addr=clr_addr, mem_wdata=0; clr_addr increments.
  - After writing address 255: clr_addr wraps to 0 and next state is IDLE. The sequence takes exactly 256 cycles.
  - clear_busy=1 for all CLEAR cycles. game_gnt=0 and disp_valid=0 throughout.
  - clear_start is ignored while in CLEAR.
- IDLE arbitration, per cycle:
  - The game wins if game_req && (!disp_req || starve_cnt==MAX_WAIT).
  - Otherwise the display wins if disp_req.
  - Otherwise the memory is idle: mem_we=0, mem_addr holds its last value.
- Game grant: game_gnt=1 that cycle; mem_addr={game_y,game_x}; mem_we=game_we; mem_wdata=game_wdata.
- Display grant: mem_addr={disp_y,disp_x}; mem_we=0.
- starve_cnt:
  - +1 on each cycle with game_req && !game_gnt, saturating at MAX_WAIT.
  - Cleared to 0 on a game grant or when game_req=0.
  - Held during CLEAR.
- Read pipeline: a read granted in cycle N produces mem_rdata in cycle N+1.
  - That data is registered into disp_data or game_rdata, tagged by the owner recorded at cycle N.
  - The matching valid pulses in cycle N+2.
  - Total read latency is 2 cycles.
  - A game write produces no game_rvalid.
- A stolen slot gives no disp_valid. disp_data keeps the previous cell, so the display repeats it for that pixel.
- Back-to-back grants of either kind are allowed every cycle. Reads are fully pipelined.
- Reset in mid-CLEAR: return to IDLE with clr_addr=0. The RAM is left partially cleared. The game must reissue clear_start.
- Reset with a read in flight: the owner tags clear, so no valid pulse follows.
- Only one grant exists per cycle, so display/game address collisions cannot occur.

Test Plan:
1. Display-only stream: disp_req=1 with (x,y) stepping (0,0),(1,0),(2,0) and RAM preloaded 7'h01,7'h0B,7'h7F -> disp_valid pulses from cycle 2 with disp_data 01,0B,7F in order; game_gnt=0.
2. Game read with disp_req=0: game_req=1, game_we=0, (x,y)=(3,5) -> game_gnt=1 the same cycle; mem_addr=8'h53; game_rvalid=1 two cycles later with the RAM contents at 0x53.
3. Starvation: disp_req held 1, game write (2,2)=7'h21 held, MAX_WAIT=4 -> game_gnt on the 5th request cycle; mem_we=1, addr=8'h22; no disp_valid two cycles after that slot; disp_data unchanged; starve_cnt back to 0.
4. Clear: clear_start pulse with game_req=1 in the same cycle -> no grant; clear_busy high for exactly 256 cycles; mem_wdata=0 at addresses 0..255 in order; game granted the first IDLE cycle after.
5. Reset mid-clear: assert rst=0 at clr_addr=100 -> clear_busy=0 and outputs 0 immediately (async); after release the state is IDLE and a new clear_start restarts from address 0.
6. Simultaneous display and game requests with starve_cnt<MAX_WAIT -> display granted; starve_cnt increments each cycle; saturates at MAX_WAIT and does not wrap.
